// File: rtl/c4_pkg.sv
// rtl/c4_pkg.sv - shared constants, state encoding and cell indexing for the Connect Four controller
package c4_pkg;

    localparam int COLS    = 7;
    localparam int ROWS    = 6;
    localparam int BOARD_W = COLS * ROWS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLACE = 2'd1,
        CHECK = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic PLAYER0 = 1'b0;
    localparam logic PLAYER1 = 1'b1;

    // Column-major layout: bit 0 is column 0 bottom, bit 41 is column 6 top.
    function automatic logic [5:0] cell_idx(input logic [2:0] loc, input logic [2:0] ht);
        return 6'(loc) * 6'(ROWS) + 6'(ht);
    endfunction

endpackage

// File: rtl/c4_col_heights.sv
// rtl/c4_col_heights.sv - seven per-column fill counters with lookup of the selected column
module c4_col_heights
    import c4_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_clear,
    input  logic       i_inc,
    input  logic [2:0] i_col,
    output logic [2:0] o_height,
    output logic       o_full
);

    logic [2:0] r_h [COLS];
    logic       w_valid;

    assign w_valid  = i_col < 3'(COLS);
    assign o_height = w_valid ? r_h[i_col] : 3'd0;
    assign o_full   = w_valid && (o_height == 3'(ROWS));

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < COLS; i++) r_h[i] <= 3'd0;
        end else if (i_clear) begin
            for (int i = 0; i < COLS; i++) r_h[i] <= 3'd0;
        end else if (i_inc && w_valid && !o_full) begin
            r_h[i_col] <= r_h[i_col] + 3'd1;
        end
    end

endmodule

// File: rtl/c4_game_ctrl.sv
// rtl/c4_game_ctrl.sv - Connect Four move sequencer: board registers, turn order, win/draw/illegal detection
module c4_game_ctrl
    import c4_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               new_game,
    input  logic               move_valid,
    input  logic [2:0]         move_col,
    output logic               move_ready,
    output logic               move_done,
    output logic               move_err,
    output logic [2:0]         location,
    output logic [2:0]         height,
    output logic               player,
    output logic [BOARD_W-1:0] player_register,
    output logic [BOARD_W-1:0] onoff_register,
    input  logic               wongame,
    output logic               game_over,
    output logic               winner,
    output logic               draw
);

    state_t             r_state;
    logic               r_player;
    logic [2:0]         r_loc;
    logic [2:0]         r_ht;
    logic [BOARD_W-1:0] r_own;
    logic [BOARD_W-1:0] r_occ;
    logic [5:0]         r_count;
    logic               r_over;
    logic               r_winner;
    logic               r_draw;
    logic               r_done;
    logic               r_err;

    logic [2:0] w_col;
    logic [2:0] w_height;
    logic       w_full;
    logic       w_inc;
    logic       w_illegal;
    logic [5:0] w_idx;

    // During PLACE the counters are addressed by the latched column, otherwise by the request.
    assign w_col     = (r_state == PLACE) ? r_loc : move_col;
    assign w_inc     = (r_state == PLACE) && !new_game;
    assign w_illegal = (move_col >= 3'(COLS)) || w_full;
    assign w_idx     = cell_idx(r_loc, r_ht);

    c4_col_heights u_col_heights (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_clear  (new_game),
        .i_inc    (w_inc),
        .i_col    (w_col),
        .o_height (w_height),
        .o_full   (w_full)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_player <= PLAYER0;
            r_loc    <= 3'd0;
            r_ht     <= 3'd0;
            r_own    <= '0;
            r_occ    <= '0;
            r_count  <= 6'd0;
            r_over   <= 1'b0;
            r_winner <= 1'b0;
            r_draw   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else if (new_game) begin
            r_state  <= IDLE;
            r_player <= PLAYER0;
            r_loc    <= 3'd0;
            r_ht     <= 3'd0;
            r_own    <= '0;
            r_occ    <= '0;
            r_count  <= 6'd0;
            r_over   <= 1'b0;
            r_winner <= 1'b0;
            r_draw   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (move_valid) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_loc   <= move_col;
                            r_ht    <= w_height;
                            r_state <= PLACE;
                        end
                    end
                end
                PLACE: begin
                    r_occ[w_idx] <= 1'b1;
                    r_own[w_idx] <= r_player;
                    r_count      <= r_count + 6'd1;
                    r_state      <= CHECK;
                end
                CHECK: begin
                    // A win on the final cell is reported as a win, not a draw.
                    if (wongame) begin
                        r_winner <= r_player;
                        r_over   <= 1'b1;
                        r_state  <= OVER;
                    end else if (r_count == 6'(BOARD_W)) begin
                        r_draw  <= 1'b1;
                        r_over  <= 1'b1;
                        r_state <= OVER;
                    end else begin
                        r_player <= (r_player == PLAYER0) ? PLAYER1 : PLAYER0;
                        r_done   <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= OVER;
            endcase
        end
    end

    assign move_ready      = (r_state == IDLE);
    assign move_done       = r_done;
    assign move_err        = r_err;
    assign location        = r_loc;
    assign height          = r_ht;
    assign player          = r_player;
    assign player_register = r_own;
    assign onoff_register  = r_occ;
    assign game_over       = r_over;
    assign winner          = r_winner;
    assign draw            = r_draw;

endmodule

// File: tb/tb_c4_game_ctrl.sv
// tb/tb_c4_game_ctrl.sv - randomized self-checking bench with a behavioural game model and win_logic stub
module tb_c4_game_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        new_game = 1'b0;
    logic        move_valid = 1'b0;
    logic [2:0]  move_col = 3'd0;
    logic        move_ready, move_done, move_err, player, game_over, winner, draw;
    logic [2:0]  location, height;
    logic [41:0] player_register, onoff_register;
    logic        wongame;

    c4_game_ctrl dut (
        .clk             (clk),
        .resetn          (resetn),
        .new_game        (new_game),
        .move_valid      (move_valid),
        .move_col        (move_col),
        .move_ready      (move_ready),
        .move_done       (move_done),
        .move_err        (move_err),
        .location        (location),
        .height          (height),
        .player          (player),
        .player_register (player_register),
        .onoff_register  (onoff_register),
        .wongame         (wongame),
        .game_over       (game_over),
        .winner          (winner),
        .draw            (draw)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mode  = 0;   // 0: real four-in-a-row, 1: never wins, 2: wins only when board is full

    function automatic bit four(logic [41:0] pr, logic [41:0] oc, int c, int r, bit p);
        int dc [4] = '{1, 0, 1, 1};
        int dr [4] = '{0, 1, 1, -1};
        for (int d = 0; d < 4; d++) begin
            int n = 1;
            for (int s = -1; s <= 1; s += 2) begin
                int cc = c + s * dc[d];
                int rr = r + s * dr[d];
                while (cc >= 0 && cc < 7 && rr >= 0 && rr < 6 && oc[cc*6+rr] && pr[cc*6+rr] == p) begin
                    n++;
                    cc += s * dc[d];
                    rr += s * dr[d];
                end
            end
            if (n >= 4) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit win_of(logic [41:0] pr, logic [41:0] oc, int c, int r, bit p);
        if (mode == 1) return 1'b0;
        if (mode == 2) return &oc;
        return four(pr, oc, c, r, p);
    endfunction

    always_comb wongame = win_of(player_register, onoff_register, int'(location), int'(height), player);

    int          m_h [7];
    logic [41:0] m_occ, m_own;
    bit          m_player, m_over, m_winner, m_draw;
    int          m_count;

    bit          chk_en = 1'b0;
    bit          e_ready, e_done, e_err, e_player, e_over, e_winner, e_draw;
    logic [2:0]  e_loc, e_ht;
    logic [41:0] e_occ, e_own;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("move_ready", 64'(move_ready), 64'(e_ready));
            chk("move_done", 64'(move_done), 64'(e_done));
            chk("move_err", 64'(move_err), 64'(e_err));
            chk("location", 64'(location), 64'(e_loc));
            chk("height", 64'(height), 64'(e_ht));
            chk("player", 64'(player), 64'(e_player));
            chk("player_register", 64'(player_register), 64'(e_own));
            chk("onoff_register", 64'(onoff_register), 64'(e_occ));
            chk("game_over", 64'(game_over), 64'(e_over));
            chk("winner", 64'(winner), 64'(e_winner));
            chk("draw", 64'(draw), 64'(e_draw));
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_h[i] = 0;
        m_occ = '0; m_own = '0; m_player = 0; m_over = 0; m_winner = 0; m_draw = 0; m_count = 0;
        e_loc = 3'd0; e_ht = 3'd0;
    endtask

    task automatic sync_exp();
        e_occ = m_occ; e_own = m_own; e_player = m_player; e_over = m_over;
        e_winner = m_winner; e_draw = m_draw; e_ready = !m_over; e_done = 0; e_err = 0;
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        @(posedge clk); #1;
        model_reset(); sync_exp();
        @(negedge clk);
        new_game = 1'b0;
    endtask

    // Accept a legal request; returns at the negedge inside PLACE.
    task automatic start_move(input int col, input bit hold);
        move_valid = 1'b1; move_col = 3'(col);
        @(posedge clk); #1;
        e_ready = 0; e_loc = 3'(col); e_ht = 3'(m_h[col]);
        @(negedge clk);
        if (!hold) move_valid = 1'b0;
    endtask

    // Board update edge; returns at the negedge inside CHECK.
    task automatic finish_place(input int col);
        int idx;
        @(posedge clk); #1;
        idx = col * 6 + m_h[col];
        m_occ[idx] = 1'b1; m_own[idx] = m_player; m_h[col]++; m_count++;
        e_occ = m_occ; e_own = m_own;
        @(negedge clk);
        move_valid = 1'b0;
    endtask

    task automatic do_move(input int col);
        if (m_over) begin
            move_valid = 1'b1; move_col = 3'(col);
            @(posedge clk); #1; sync_exp();
            @(negedge clk); move_valid = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
        end else if (col > 6 || m_h[col] == 6) begin
            move_valid = 1'b1; move_col = 3'(col);
            @(posedge clk); #1; sync_exp(); e_err = 1;
            @(negedge clk); move_valid = 1'b0;
            @(posedge clk); #1; e_err = 0;
            @(negedge clk);
        end else begin
            bit won;
            int h = m_h[col];
            start_move(col, bit'($urandom_range(0, 1)));
            finish_place(col);
            @(posedge clk); #1;
            won = win_of(m_own, m_occ, col, h, m_player);
            if (won) begin
                m_over = 1; m_winner = m_player;
                sync_exp();
            end else if (m_count == 42) begin
                m_over = 1; m_draw = 1;
                sync_exp();
            end else begin
                m_player = !m_player;
                sync_exp(); e_done = 1;
            end
            @(negedge clk);
            @(posedge clk); #1; e_done = 0;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_onoff", 64'(onoff_register), 64'd0);
        chk("reset_ready", 64'(move_ready), 64'd1);
        resetn = 1'b1;
        model_reset(); sync_exp();
        chk_en = 1'b1;
        @(negedge clk);

        // first move in column 3 lands on bit 18
        do_move(3);
        chk("col3_onoff", 64'(onoff_register), 64'h40000);
        chk("col3_player", 64'(player), 64'd1);

        // fill column 0, then overflow it and try an out-of-range column
        do_new_game();
        for (int i = 0; i < 7; i++) do_move(0);
        chk("col0_onoff", 64'(onoff_register), 64'h3F);
        chk("col0_owner", 64'(player_register), 64'h2A);
        do_move(7);

        // horizontal win for player 0 on the bottom row
        do_new_game();
        mode = 0;
        begin
            int seq [7] = '{0, 6, 1, 6, 2, 6, 3};
            for (int i = 0; i < 7; i++) do_move(seq[i]);
        end
        chk("win_over", 64'(game_over), 64'd1);
        chk("win_winner", 64'(winner), 64'd0);
        chk("win_player", 64'(player), 64'd0);
        chk("win_onoff", 64'(onoff_register), 64'h7000041041);
        do_move(4);
        do_move(7);

        // full board without a win, then full board where the last piece wins
        for (int pass = 1; pass <= 2; pass++) begin
            do_new_game();
            mode = pass;
            for (int it = 0; it < 600 && !m_over; it++) do_move($urandom_range(0, 7));
            chk("full_over", 64'(game_over), 64'd1);
            chk("full_draw", 64'(draw), (pass == 1) ? 64'd1 : 64'd0);
            chk("full_winner", 64'(winner), (pass == 1) ? 64'd0 : 64'd1);
        end

        // random games with real win detection
        mode = 0;
        for (int g = 0; g < 4; g++) begin
            do_new_game();
            for (int it = 0; it < 120 && !m_over; it++) do_move($urandom_range(0, 7));
            do_move($urandom_range(0, 7));
        end

        // new_game while the piece is being placed
        do_new_game();
        do_move(2); do_move(2);
        start_move(4, 1'b0);
        new_game = 1'b1;
        @(posedge clk); #1;
        model_reset(); sync_exp();
        @(negedge clk); new_game = 1'b0;
        chk("abort_onoff", 64'(onoff_register), 64'd0);
        repeat (3) begin @(posedge clk); #1; @(negedge clk); end
        do_move(4);
        chk("abort_height", 64'(height), 64'd0);

        // asynchronous reset while the move is being checked
        do_move(1);
        start_move(5, 1'b0);
        finish_place(5);
        chk_en = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("areset_onoff", 64'(onoff_register), 64'd0);
        chk("areset_owner", 64'(player_register), 64'd0);
        chk("areset_player", 64'(player), 64'd0);
        chk("areset_loc", 64'(location), 64'd0);
        chk("areset_done", 64'(move_done), 64'd0);
        model_reset(); sync_exp();
        @(negedge clk);
        resetn = 1'b1;
        chk_en = 1'b1;
        do_move(6);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/c4_game_ctrl.md
Name: c4_game_ctrl

Overview:
Sequencing controller for the Connect Four board state. It accepts column-drop requests and keeps per-column fill heights. It owns the 42-bit player and on/off board registers and drives location/height/player to the combinational win_logic block. It samples win_logic's wongame result, alternates turns, and detects win, draw and illegal moves.

Parameters:
COLS, 7, number of columns; location width 3
ROWS, 6, number of rows; height width 3; board width COLS*ROWS = 42
Only the defaults are supported, because win_logic is fixed at 42 bits and 3-bit indices.

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous, active-low reset
new_game  in  1  synchronous clear to a fresh game; priority over everything except resetn
move_valid  in  1  drop request
move_col  in  3  requested column, 0..6
move_ready  out  1  high only in IDLE
move_done  out  1  1-cycle pulse: legal move placed, no win/draw, turn passed
move_err  out  1  1-cycle pulse: illegal request rejected
location  out  3  column of the last placed piece, to win_logic
height  out  3  row of the last placed piece (0 = bottom), to win_logic
player  out  1  player whose turn it is / who placed the piece under check; 0 = first player
player_register  out  42  bit = 1 where player 1 owns the cell
onoff_register  out  42  bit = 1 where the cell is occupied
wongame  in  1  combinational result from win_logic
game_over  out  1  level, high in OVER
winner  out  1  valid when game_over && !draw
draw  out  1  level, board full with no win

Behaviour:
- Cell index is location*6 + height. Bit 0 is column 0 bottom; bit 41 is column 6 top.
- Reset (resetn=0, asynchronous) and new_game (synchronous) produce the same state:
  - all registers 0, all seven col_height counters 0, move_count 0
  - player=0, location=0, height=0, game_over=0, winner=0, draw=0, pulses 0
  - state IDLE
- IDLE: move_ready=1. On move_valid:
  - If move_col>6 or col_height[move_col]==6: move_err=1 for the next cycle, stay IDLE, no state change.
  - Otherwise latch location=move_col and height=col_height[move_col], then go to PLACE.
- PLACE (1 cycle):
  - set onoff_register[idx]=1 and player_register[idx]=player
  - col_height[location]+=1 and move_count+=1 (6-bit, max 42)
  - go to CHECK
- CHECK (1 cycle): registers are now updated, so wongame reflects the new piece.
  - If wongame=1: winner=player, game_over=1, go to OVER. player is not toggled.
  - Else if move_count==42: draw=1, game_over=1, go to OVER.
  - Else: toggle player, pulse move_done, go to IDLE.
  - Win takes priority over draw when the 42nd move also wins.
- OVER: move_ready=0. move_valid is ignored; no move_err is raised. Stays in OVER until new_game or reset.
- Latency: request accepted at cycle N, board updated at N+1, move_done/game_over at N+2. The earliest next acceptance is N+3.
- move_valid in PLACE/CHECK is ignored (move_ready=0). The requester holds move_valid until it sees move_ready.
- new_game in PLACE or CHECK aborts the move, with no partial update, and no pulses are emitted.
- location, height and player are stable from PLACE through CHECK.
- col_height never exceeds 6. move_count never exceeds 42.

Decomposition:
- Shared package c4_pkg:
  - COLS, ROWS, BOARD_W=42
  - state encoding IDLE=2'd0, PLACE=2'd1, CHECK=2'd2, OVER=2'd3
  - PLAYER0/PLAYER1 constants
  - cell-index function location*ROWS+height
- One natural sub-module: c4_col_heights, holding the seven 3-bit fill counters.
  - Inputs: clear, inc, col.
  - Outputs: height of the selected column and a full flag.
- The FSM and board registers stay in c4_game_ctrl. win_logic is instantiated beside it, not inside it.

Test Plan:
- Reset, then move col 3: at N+1 onoff bit 18=1 and player bit 18=0; at N+2 move_done=1 and player toggles to 1.
- Seven alternating drops into col 0: drops 1-6 fill heights 0..5 (bits 0..5, player bits 0,1,0,1,0,1). The 7th drop gives move_err=1 and leaves the board unchanged.
- move_col=7 → move_err pulse, move_count unchanged, state IDLE.
- Player 0 in cols 0,1,2,3 interleaved with player 1 in col 6:
  - With a behavioural win_logic stub asserting wongame on the 4th in-row piece, the 7th move gives game_over=1, winner=0, draw=0, and player stays 0.
  - Further move_valid → no move_err, board frozen.
- Force 42 non-winning moves (stub wongame=0): the 42nd gives draw=1 and game_over=1. Repeat with wongame=1 on the 42nd: draw=0, winner set.
- Reset or new_game mid-operation:
  - Assert new_game in PLACE: next cycle both registers are 0, player=0, IDLE, no move_done.
  - Pulse resetn low asynchronously mid-CHECK: all outputs 0 immediately.
